// File: rtl/pipe_hold_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipe_hold_ctrl_pkg
// Shared definitions for the pipeline hold/flush controller: bus widths, the
// hold_flag encodings consumed by every pipeline register, the controller FSM
// state type and a packed bundle of the combinational control outputs.
// Hold_X freezes the PC and every pipeline register up to and including the
// one feeding stage X.
// ----------------------------------------------------------------------------
package pipe_hold_ctrl_pkg;

    localparam int DATA_W = 16;
    localparam int HOLD_W = 3;

    localparam logic [HOLD_W-1:0] HOLD_NONE = 3'd0;
    localparam logic [HOLD_W-1:0] HOLD_PC   = 3'd1;
    localparam logic [HOLD_W-1:0] HOLD_IF   = 3'd2;
    localparam logic [HOLD_W-1:0] HOLD_ID   = 3'd3;
    localparam logic [HOLD_W-1:0] HOLD_EX   = 3'd4;
    localparam logic [HOLD_W-1:0] HOLD_PPL  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_ENTER = 2'd2
    } ctrl_state_e;

    // Combinational controls produced each cycle (epc/int_active are separate
    // because they are registered).
    typedef struct packed {
        logic [HOLD_W-1:0] hold_flag;
        logic              flush_id;
        logic              bubble_ex;
        logic              pc_load;
        logic [DATA_W-1:0] pc_target;
        logic              int_ack;
    } ctrl_out_t;

    // Quiet cycle: nothing held, nothing redirected.
    function automatic ctrl_out_t ctrl_none();
        ctrl_out_t o;
        o.hold_flag = HOLD_NONE;
        o.flush_id  = 1'b0;
        o.bubble_ex = 1'b0;
        o.pc_load   = 1'b0;
        o.pc_target = {DATA_W{1'b0}};
        o.int_ack   = 1'b0;
        return o;
    endfunction

    // PC redirect: kill the instruction in IF and bubble EX so nothing from
    // the wrong path survives.
    function automatic ctrl_out_t ctrl_redirect(input logic [DATA_W-1:0] target);
        ctrl_out_t o;
        o           = ctrl_none();
        o.flush_id  = 1'b1;
        o.bubble_ex = 1'b1;
        o.pc_load   = 1'b1;
        o.pc_target = target;
        return o;
    endfunction

endpackage

// File: rtl/pipe_hold_ctrl_if.sv
// ----------------------------------------------------------------------------
// pipe_hold_ctrl_if
// Bundle between the hold controller and the pipeline.
//  Requests into the controller : mem_busy, ld_use_req, jump_req, jump_addr,
//                                 int_req, int_en, mret_req, ex_pc
//  Controls out of controller   : hold_flag, flush_id, bubble_ex, pc_load,
//                                 pc_target, int_ack, int_active, epc
// Modport ctrl is the controller side, modport pipe is the pipeline side.
// ----------------------------------------------------------------------------
interface pipe_hold_ctrl_if
    import pipe_hold_ctrl_pkg::*;
();

    logic              mem_busy;
    logic              ld_use_req;
    logic              jump_req;
    logic [DATA_W-1:0] jump_addr;
    logic              int_req;
    logic              int_en;
    logic              mret_req;
    logic [DATA_W-1:0] ex_pc;

    logic [HOLD_W-1:0] hold_flag;
    logic              flush_id;
    logic              bubble_ex;
    logic              pc_load;
    logic [DATA_W-1:0] pc_target;
    logic              int_ack;
    logic              int_active;
    logic [DATA_W-1:0] epc;

    modport ctrl (
        input  mem_busy, ld_use_req, jump_req, jump_addr,
               int_req, int_en, mret_req, ex_pc,
        output hold_flag, flush_id, bubble_ex, pc_load,
               pc_target, int_ack, int_active, epc
    );

    modport pipe (
        output mem_busy, ld_use_req, jump_req, jump_addr,
               int_req, int_en, mret_req, ex_pc,
        input  hold_flag, flush_id, bubble_ex, pc_load,
               pc_target, int_ack, int_active, epc
    );

endinterface

// File: rtl/pipe_hold_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_hold_ctrl
// Central hold/flush controller for the 3-stage pipeline and sole driver of
// hold_flag. Arbitrates memory-busy freezes, load-use bubbles, branch/jump
// redirects and interrupt entry/return. Interrupt entry is sequenced by a
// drain FSM (IDLE -> DRAIN -> ENTER) that holds the front end while in-flight
// work retires, then saves EPC and redirects the PC to INT_VECTOR.
// Ports:
//  clk    rising-edge clock
//  rst_n  asynchronous active-low reset
//  bus    pipe_hold_ctrl_if.ctrl (requests in, hold/flush/redirect out)
// All controls are combinational from FSM state and inputs, except epc and
// int_active which are registered.
// ----------------------------------------------------------------------------
module pipe_hold_ctrl
    import pipe_hold_ctrl_pkg::*;
#(
    parameter logic [DATA_W-1:0] INT_VECTOR   = 16'h0004,
    parameter int                DRAIN_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    pipe_hold_ctrl_if.ctrl   bus
);

    localparam int              CNT_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    ctrl_state_e        state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [DATA_W-1:0]  epc_r;
    logic               int_active_r;
    logic               accept_s;
    ctrl_out_t          out_s;

    // Interrupt acceptance; a same-cycle jump or return takes precedence and
    // the request is simply looked at again on a later cycle.
    assign accept_s = bus.int_req & bus.int_en & ~int_active_r
                    & ~bus.jump_req & ~bus.mret_req;

    // FSM, drain counter and the registered interrupt context; everything is
    // frozen while memory is busy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            cnt_r        <= CNT_ZERO;
            epc_r        <= {DATA_W{1'b0}};
            int_active_r <= 1'b0;
        end else if (!bus.mem_busy) begin
            unique case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r <= ST_DRAIN;
                        cnt_r   <= CNT_LOAD;
                    end
                    if (bus.mret_req && !bus.jump_req) begin
                        int_active_r <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (bus.jump_req) begin
                        // Redirect wins; the interrupt is re-arbitrated from IDLE.
                        state_r <= ST_IDLE;
                        cnt_r   <= CNT_ZERO;
                    end else if (cnt_r == CNT_ZERO) begin
                        state_r <= ST_ENTER;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                ST_ENTER: begin
                    state_r      <= ST_IDLE;
                    epc_r        <= bus.ex_pc;
                    int_active_r <= 1'b1;
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= CNT_ZERO;
                end
            endcase
        end
    end

    // Per-cycle priority arbitration of the combinational controls.
    always_comb begin
        out_s = ctrl_none();
        if (bus.mem_busy) begin
            out_s.hold_flag = HOLD_PPL;
        end else if (state_r == ST_DRAIN) begin
            if (bus.jump_req) begin
                out_s = ctrl_redirect(bus.jump_addr);
            end else begin
                out_s.hold_flag = HOLD_ID;
                out_s.bubble_ex = 1'b1;
            end
        end else if (state_r == ST_ENTER) begin
            out_s         = ctrl_redirect(INT_VECTOR);
            out_s.int_ack = 1'b1;
        end else if (bus.jump_req) begin
            out_s = ctrl_redirect(bus.jump_addr);
        end else if (bus.mret_req) begin
            out_s = ctrl_redirect(epc_r);
        end else if (bus.ld_use_req) begin
            out_s.hold_flag = HOLD_ID;
            out_s.bubble_ex = 1'b1;
        end else begin
            out_s = ctrl_none();
        end
    end

    assign bus.hold_flag  = out_s.hold_flag;
    assign bus.flush_id   = out_s.flush_id;
    assign bus.bubble_ex  = out_s.bubble_ex;
    assign bus.pc_load    = out_s.pc_load;
    assign bus.pc_target  = out_s.pc_target;
    assign bus.int_ack    = out_s.int_ack;
    assign bus.int_active = int_active_r;
    assign bus.epc        = epc_r;

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pipe_hold_ctrl
// Self-checking bench for pipe_hold_ctrl. Each scenario task builds a table of
// per-cycle stimulus with the expected output word; the expected word is
// pushed to a scoreboard queue when the stimulus is driven (on the falling
// edge) and popped and compared once outputs have settled mid-cycle.
// Output word: {hold_flag, flush_id, bubble_ex, pc_load, pc_target, int_ack,
//               int_active, epc}
// ----------------------------------------------------------------------------
module tb_pipe_hold_ctrl;
    import pipe_hold_ctrl_pkg::*;

    logic clk;
    logic rst_n;

    pipe_hold_ctrl_if ifc ();

    pipe_hold_ctrl #(
        .INT_VECTOR   (16'h0004),
        .DRAIN_CYCLES (2)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        mb;
        logic        ld;
        logic        jr;
        logic [15:0] ja;
        logic        ir;
        logic        ie;
        logic        mr;
        logic [15:0] xp;
        logic [39:0] exp;
    } stim_t;

    logic [39:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic logic [39:0] ex(input logic [2:0] hold, input logic fl,
                                       input logic bb, input logic ld,
                                       input logic [15:0] tgt, input logic ack,
                                       input logic act, input logic [15:0] epc);
        return {hold, fl, bb, ld, tgt, ack, act, epc};
    endfunction

    function automatic stim_t st(input logic rst, input logic mb, input logic ld,
                                 input logic jr, input logic [15:0] ja,
                                 input logic ir, input logic ie, input logic mr,
                                 input logic [15:0] xp, input logic [39:0] e);
        stim_t s;
        s.rst = rst; s.mb = mb; s.ld = ld; s.jr = jr; s.ja = ja;
        s.ir = ir; s.ie = ie; s.mr = mr; s.xp = xp; s.exp = e;
        return s;
    endfunction

    function automatic logic [39:0] obs();
        return {ifc.hold_flag, ifc.flush_id, ifc.bubble_ex, ifc.pc_load,
                ifc.pc_target, ifc.int_ack, ifc.int_active, ifc.epc};
    endfunction

    task automatic apply(input stim_t s);
        rst_n          = s.rst;
        ifc.mem_busy   = s.mb;
        ifc.ld_use_req = s.ld;
        ifc.jump_req   = s.jr;
        ifc.jump_addr  = s.ja;
        ifc.int_req    = s.ir;
        ifc.int_en     = s.ie;
        ifc.mret_req   = s.mr;
        ifc.ex_pc      = s.xp;
        exp_q.push_back(s.exp);
    endtask

    task automatic test_reset();
        stim_t t[$];
        logic [39:0] e, o;
        t.push_back(st(0,0,0,0,16'h0,0,0,0,16'h0, ex(3'd0,0,0,0,16'h0,0,0,16'h0)));
        t.push_back(st(1,0,0,0,16'h0,0,0,0,16'h0, ex(3'd0,0,0,0,16'h0,0,0,16'h0)));
        for (int i = 0; i < t.size(); i++) begin
            apply(t[i]); #2;
            e = exp_q.pop_front(); o = obs(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL reset[%0d] got=%h exp=%h", i, o, e); end
            @(negedge clk);
        end
    endtask

    task automatic test_ld_use();
        stim_t t[$];
        logic [39:0] e, o;
        t.push_back(st(1,0,1,0,16'h0,0,0,0,16'h0, ex(3'd3,0,1,0,16'h0,0,0,16'h0)));
        t.push_back(st(1,0,0,0,16'h0,0,0,0,16'h0, ex(3'd0,0,0,0,16'h0,0,0,16'h0)));
        t.push_back(st(1,0,1,1,16'h0040,0,0,0,16'h0, ex(3'd0,1,1,1,16'h0040,0,0,16'h0)));
        t.push_back(st(1,0,0,0,16'h0,0,0,0,16'h0, ex(3'd0,0,0,0,16'h0,0,0,16'h0)));
        for (int i = 0; i < t.size(); i++) begin
            apply(t[i]); #2;
            e = exp_q.pop_front(); o = obs(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL ld_use[%0d] got=%h exp=%h", i, o, e); end
            @(negedge clk);
        end
    endtask

    task automatic test_jump_priority();
        stim_t t[$];
        logic [39:0] e, o;
        t.push_back(st(1,0,0,1,16'h0080,0,0,1,16'h0, ex(3'd0,1,1,1,16'h0080,0,0,16'h0)));
        t.push_back(st(1,1,0,1,16'h0080,0,0,0,16'h0, ex(3'd5,0,0,0,16'h0,0,0,16'h0)));
        t.push_back(st(1,1,1,0,16'h0,0,0,0,16'h0, ex(3'd5,0,0,0,16'h0,0,0,16'h0)));
        t.push_back(st(1,0,0,0,16'h0,0,0,1,16'h0, ex(3'd0,1,1,1,16'h0,0,0,16'h0)));
        t.push_back(st(1,0,0,0,16'h0,0,0,0,16'h0, ex(3'd0,0,0,0,16'h0,0,0,16'h0)));
        for (int i = 0; i < t.size(); i++) begin
            apply(t[i]); #2;
            e = exp_q.pop_front(); o = obs(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL jump_prio[%0d] got=%h exp=%h", i, o, e); end
            @(negedge clk);
        end
    endtask

    task automatic test_int_disabled();
        stim_t t[$];
        logic [39:0] e, o;
        for (int k = 0; k < 3; k++)
            t.push_back(st(1,0,0,0,16'h0,1,0,0,16'h0111, ex(3'd0,0,0,0,16'h0,0,0,16'h0)));
        t.push_back(st(1,0,0,0,16'h0,0,1,0,16'h0111, ex(3'd0,0,0,0,16'h0,0,0,16'h0)));
        t.push_back(st(1,0,0,0,16'h0,0,1,0,16'h0111, ex(3'd0,0,0,0,16'h0,0,0,16'h0)));
        for (int i = 0; i < t.size(); i++) begin
            apply(t[i]); #2;
            e = exp_q.pop_front(); o = obs(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL int_disabled[%0d] got=%h exp=%h", i, o, e); end
            @(negedge clk);
        end
    endtask

    task automatic test_interrupt_entry();
        stim_t t[$];
        logic [39:0] e, o;
        t.push_back(st(1,0,0,0,16'h0,1,1,0,16'h0120, ex(3'd0,0,0,0,16'h0,0,0,16'h0)));
        t.push_back(st(1,0,0,0,16'h0,1,1,0,16'h0120, ex(3'd3,0,1,0,16'h0,0,0,16'h0)));
        t.push_back(st(1,0,0,0,16'h0,1,1,0,16'h0120, ex(3'd3,0,1,0,16'h0,0,0,16'h0)));
        t.push_back(st(1,0,0,0,16'h0,1,1,0,16'h0120, ex(3'd0,1,1,1,16'h0004,1,0,16'h0)));
        t.push_back(st(1,0,0,0,16'h0,1,1,0,16'h0130, ex(3'd0,0,0,0,16'h0,0,1,16'h0120)));
        t.push_back(st(1,0,0,0,16'h0,1,1,0,16'h0130, ex(3'd0,0,0,0,16'h0,0,1,16'h0120)));
        t.push_back(st(1,0,0,0,16'h0,0,1,1,16'h0130, ex(3'd0,1,1,1,16'h0120,0,1,16'h0120)));
        t.push_back(st(1,0,0,0,16'h0,0,1,0,16'h0130, ex(3'd0,0,0,0,16'h0,0,0,16'h0120)));
        for (int i = 0; i < t.size(); i++) begin
            apply(t[i]); #2;
            e = exp_q.pop_front(); o = obs(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL int_entry[%0d] got=%h exp=%h", i, o, e); end
            @(negedge clk);
        end
    endtask

    task automatic test_mem_busy_drain();
        stim_t t[$];
        logic [39:0] e, o;
        t.push_back(st(1,0,0,0,16'h0,1,1,0,16'h0200, ex(3'd0,0,0,0,16'h0,0,0,16'h0120)));
        // int_req drops during DRAIN: acceptance is already committed.
        t.push_back(st(1,0,0,0,16'h0,0,1,0,16'h0200, ex(3'd3,0,1,0,16'h0,0,0,16'h0120)));
        for (int k = 0; k < 3; k++)
            t.push_back(st(1,1,0,0,16'h0,0,1,0,16'h0200, ex(3'd5,0,0,0,16'h0,0,0,16'h0120)));
        t.push_back(st(1,0,0,0,16'h0,0,1,0,16'h0200, ex(3'd3,0,1,0,16'h0,0,0,16'h0120)));
        t.push_back(st(1,0,0,0,16'h0,0,1,0,16'h0200, ex(3'd0,1,1,1,16'h0004,1,0,16'h0120)));
        t.push_back(st(1,0,0,0,16'h0,0,1,0,16'h0210, ex(3'd0,0,0,0,16'h0,0,1,16'h0200)));
        t.push_back(st(1,0,0,0,16'h0,0,1,1,16'h0210, ex(3'd0,1,1,1,16'h0200,0,1,16'h0200)));
        t.push_back(st(1,0,0,0,16'h0,0,1,0,16'h0210, ex(3'd0,0,0,0,16'h0,0,0,16'h0200)));
        for (int i = 0; i < t.size(); i++) begin
            apply(t[i]); #2;
            e = exp_q.pop_front(); o = obs(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL mem_busy_drain[%0d] got=%h exp=%h", i, o, e); end
            @(negedge clk);
        end
    endtask

    task automatic test_jump_in_drain();
        stim_t t[$];
        logic [39:0] e, o;
        t.push_back(st(1,0,0,0,16'h0,1,1,0,16'h0300, ex(3'd0,0,0,0,16'h0,0,0,16'h0200)));
        t.push_back(st(1,0,0,1,16'h0040,1,1,0,16'h0300, ex(3'd0,1,1,1,16'h0040,0,0,16'h0200)));
        t.push_back(st(1,0,0,0,16'h0,1,1,0,16'h0300, ex(3'd0,0,0,0,16'h0,0,0,16'h0200)));
        t.push_back(st(1,0,0,0,16'h0,1,1,0,16'h0300, ex(3'd3,0,1,0,16'h0,0,0,16'h0200)));
        t.push_back(st(1,0,0,0,16'h0,1,1,0,16'h0300, ex(3'd3,0,1,0,16'h0,0,0,16'h0200)));
        t.push_back(st(1,0,0,0,16'h0,1,1,0,16'h0300, ex(3'd0,1,1,1,16'h0004,1,0,16'h0200)));
        t.push_back(st(1,0,0,0,16'h0,0,1,0,16'h0310, ex(3'd0,0,0,0,16'h0,0,1,16'h0300)));
        t.push_back(st(1,0,0,0,16'h0,0,1,1,16'h0310, ex(3'd0,1,1,1,16'h0300,0,1,16'h0300)));
        t.push_back(st(1,0,0,0,16'h0,0,1,0,16'h0310, ex(3'd0,0,0,0,16'h0,0,0,16'h0300)));
        for (int i = 0; i < t.size(); i++) begin
            apply(t[i]); #2;
            e = exp_q.pop_front(); o = obs(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL jump_in_drain[%0d] got=%h exp=%h", i, o, e); end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_in_enter();
        stim_t t[$];
        logic [39:0] e, o;
        t.push_back(st(1,0,0,0,16'h0,1,1,0,16'h0400, ex(3'd0,0,0,0,16'h0,0,0,16'h0300)));
        t.push_back(st(1,0,0,0,16'h0,0,1,0,16'h0400, ex(3'd3,0,1,0,16'h0,0,0,16'h0300)));
        t.push_back(st(1,0,0,0,16'h0,0,1,0,16'h0400, ex(3'd3,0,1,0,16'h0,0,0,16'h0300)));
        // FSM is now in ENTER; asynchronous reset must abort it at once.
        t.push_back(st(0,0,0,0,16'h0,0,1,0,16'h0400, ex(3'd0,0,0,0,16'h0,0,0,16'h0)));
        t.push_back(st(1,0,0,0,16'h0,0,1,0,16'h0400, ex(3'd0,0,0,0,16'h0,0,0,16'h0)));
        t.push_back(st(1,0,0,0,16'h0,0,1,0,16'h0400, ex(3'd0,0,0,0,16'h0,0,0,16'h0)));
        t.push_back(st(1,0,0,0,16'h0,0,1,0,16'h0400, ex(3'd0,0,0,0,16'h0,0,0,16'h0)));
        for (int i = 0; i < t.size(); i++) begin
            apply(t[i]); #2;
            e = exp_q.pop_front(); o = obs(); n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL reset_in_enter[%0d] got=%h exp=%h", i, o, e); end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_ld_use();
        test_jump_priority();
        test_int_disabled();
        test_interrupt_entry();
        test_mem_busy_drain();
        test_jump_in_drain();
        test_reset_in_enter();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
